// File: rtl/multi_pop_fifo.sv
`default_nettype none
// ============================================================================
// Module  : multi_pop_fifo
// Brief   : Single-push, multi-pop FIFO over a circular buffer of arbitrary
//           depth. Up to POP_WIDTH oldest elements are presented per cycle,
//           with a same-cycle bypass of the incoming element when the visible
//           window is not yet full.
// Revision: 1.0 - initial release
// ============================================================================
module multi_pop_fifo #(
    parameter int DATA_WIDTH = 4,
    parameter int POP_WIDTH  = 4,
    parameter int ELEMENTS   = 9
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [DATA_WIDTH-1:0]               din,
    input  logic                                din_valid,
    output logic                                din_ready,
    output logic [POP_WIDTH*DATA_WIDTH-1:0]     dout,
    output logic [$clog2(POP_WIDTH+1)-1:0]      dout_valid_ct,
    input  logic [$clog2(POP_WIDTH+1)-1:0]      dout_ready_ct
);

    localparam int CNT_W = $clog2(POP_WIDTH + 1);
    localparam int OCC_W = $clog2(ELEMENTS + 1);
    // One extra bit so count + push never overflows the arithmetic.
    localparam int AW    = OCC_W + 1;
    localparam int PTR_W = (ELEMENTS > 1) ? $clog2(ELEMENTS) : 1;
    localparam int SW    = PTR_W + AW;

    // Pointer advance modulo ELEMENTS. ptr < ELEMENTS and inc <= ELEMENTS,
    // so a single conditional subtract is always enough.
    function automatic logic [PTR_W-1:0] wrap_add(input logic [PTR_W-1:0] ptr,
                                                  input logic [AW-1:0]    inc);
        logic [SW-1:0] sum;
        sum = SW'(ptr) + SW'(inc);
        if (sum >= SW'(ELEMENTS)) begin
            sum = sum - SW'(ELEMENTS);
        end
        return sum[PTR_W-1:0];
    endfunction

    logic [DATA_WIDTH-1:0] mem_q [ELEMENTS];
    logic [PTR_W-1:0]      head_q, head_d;
    logic [PTR_W-1:0]      tail_q, tail_d;
    logic [OCC_W-1:0]      count_q, count_d;

    logic                  w_push;
    logic                  w_write;
    logic                  w_bypass_taken;
    logic [AW-1:0]         w_count;
    logic [AW-1:0]         w_visible;
    logic [AW-1:0]         w_valid_ct;
    logic [AW-1:0]         w_ready_ct;
    logic [AW-1:0]         w_pop;
    logic [AW-1:0]         w_stored_pop;

    // Ready depends only on registered occupancy.
    assign din_ready      = (count_q < OCC_W'(ELEMENTS));
    assign w_push         = din_valid & din_ready;

    assign w_count        = AW'(count_q);
    assign w_visible      = w_count + AW'(w_push);
    assign w_valid_ct     = (w_visible > AW'(POP_WIDTH)) ? AW'(POP_WIDTH) : w_visible;
    assign dout_valid_ct  = w_valid_ct[CNT_W-1:0];

    // Consumer may ask for more than is visible; clamp to what is offered.
    assign w_ready_ct     = AW'(dout_ready_ct);
    assign w_pop          = (w_ready_ct < w_valid_ct) ? w_ready_ct : w_valid_ct;

    // Popping past the stored elements can only mean the bypassed element
    // was taken too; it then never touches storage.
    assign w_bypass_taken = (w_pop > w_count);
    assign w_stored_pop   = w_bypass_taken ? w_count : w_pop;
    assign w_write        = w_push & ~w_bypass_taken;

    // Next-state pointers and occupancy.
    always_comb begin
        head_d  = wrap_add(head_q, w_stored_pop);
        tail_d  = w_write ? wrap_add(tail_q, AW'(1)) : tail_q;
        count_d = OCC_W'(w_count + AW'(w_write) - w_stored_pop);
    end

    // Output lanes: stored elements first, then the bypassed element, then zero.
    for (genvar k = 0; k < POP_WIDTH; k++) begin : g_lane
        localparam logic [AW-1:0] c_LANE = AW'(k);
        logic [PTR_W-1:0]      w_rd_idx;
        logic [DATA_WIDTH-1:0] w_lane;

        assign w_rd_idx = wrap_add(head_q, c_LANE);

        // Select the lane source by position relative to occupancy.
        always_comb begin
            w_lane = '0;
            if (c_LANE < w_count) begin
                w_lane = mem_q[w_rd_idx];
            end else if ((c_LANE == w_count) && w_push) begin
                w_lane = din;
            end
        end

        assign dout[k*DATA_WIDTH +: DATA_WIDTH] = w_lane;
    end

    // Pointer and occupancy registers, cleared asynchronously.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Storage write; contents are not reset, and nothing is written during reset.
    always_ff @(posedge clk) begin
        if (w_write && !rst) begin
            mem_q[tail_q] <= din;
        end
    end

endmodule
`default_nettype wire
